// File: rtl/mem_pkg.sv
// Shared sizes and types for the data-memory store arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  localparam int DATA_W = 16;              // one memory word / vector lane
  localparam int LANES  = 16;              // lanes per vector store = writes per burst
  localparam int ADDR_W = 16;              // memory word-address width
  localparam int IDX_W  = $clog2(LANES);   // lane index width

  // Lane 0 occupies the lowest DATA_W bits of the packed vector.
  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vec_lane_sequencer.sv
// Latches a whole vector store and walks its lanes, producing the next lane's address/data.
// Latency: lane k of a burst is offered for registration k edges after the load edge.
// Backpressure: none; the caller decides when to load and when to step.
module vec_lane_sequencer
  import mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic [ADDR_W-1:0]       load_base,
  input  logic [LANES*DATA_W-1:0] load_lanes,
  output logic                    last,
  output logic [ADDR_W-1:0]       nxt_addr,
  output logic [DATA_W-1:0]       nxt_data,
  output logic                    vec_done
);

  lane_vec_t          lanes;
  logic [ADDR_W-1:0]  base;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;

  // The lane after the one currently on the memory port. It only matters
  // while the burst is not on its last lane, so the wrap past LANES-1 is harmless.
  assign idx_nxt  = idx + 1'b1;
  assign last     = (idx == IDX_W'(LANES - 1));
  // Address adds are kept at ADDR_W bits so bursts wrap around the top of memory.
  assign nxt_addr = base + ADDR_W'(idx_nxt);
  assign nxt_data = lanes[idx_nxt];

  // Capture the full vector at the grant edge; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      base  <= load_base;
      lanes <= load_lanes;
    end
  end

  // Lane counter and the done pulse that lines up with the last lane's write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx      <= '0;
      vec_done <= 1'b0;
    end else if (load) begin
      idx      <= '0;
      vec_done <= 1'b0;
    end else begin
      if (step) begin
        idx <= idx_nxt;
      end
      vec_done <= step && (idx == IDX_W'(LANES - 2));
    end
  end

endmodule

// File: rtl/mem_store_arbiter.sv
// Shares the single data-memory write port between the scalar and vector store units.
// Latency: scalar write 1 cycle after grant; vector lanes on cycles 1..LANES after grant.
// Backpressure: grants only while idle or on a burst's last lane; stall holds the pipeline otherwise.
module mem_store_arbiter
  import mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sc_req,
  input  logic [ADDR_W-1:0]       sc_addr,
  input  logic [DATA_W-1:0]       sc_data,
  input  logic                    vec_req,
  input  logic [ADDR_W-1:0]       vec_addr,
  input  logic [LANES*DATA_W-1:0] vec_data,
  output logic                    sc_gnt,
  output logic                    vec_gnt,
  output logic                    stall,
  output logic                    busy,
  output logic                    vec_done,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata
);

  arb_state_t         state;
  logic               prio;        // 0: scalar wins a tie, 1: vector wins a tie
  logic               last;
  logic               accept;
  logic               contended;
  logic               step;
  lane_vec_t          vec_lanes;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [DATA_W-1:0]  nxt_data;

  assign vec_lanes = vec_data;

  // Grant decision for the coming edge: idle, or the last lane of a burst so
  // the next store follows without a bubble. Nothing is granted during reset.
  always_comb begin
    accept    = rst & ((state == IDLE) | ((state == BURST) & last));
    contended = accept & sc_req & vec_req;
    sc_gnt    = accept & sc_req  & (~vec_req | ~prio);
    vec_gnt   = accept & vec_req & (~sc_req  |  prio);
    stall     = (sc_req & ~sc_gnt) | (vec_req & ~vec_gnt);
    step      = (state == BURST) & ~last;
  end

  vec_lane_sequencer u_seq (
    .clk        (clk),
    .rst        (rst),
    .load       (vec_gnt),
    .step       (step),
    .load_base  (vec_addr),
    .load_lanes (vec_data),
    .last       (last),
    .nxt_addr   (nxt_addr),
    .nxt_data   (nxt_data),
    .vec_done   (vec_done)
  );

  // Arbiter FSM, tie-break priority and the registered memory write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // A tie hands the next tie to whoever just lost.
      if (contended) begin
        prio <= ~prio;
      end
      if (vec_gnt) begin
        // Lane 0 comes straight from the inputs; the sequencer supplies the rest.
        state     <= BURST;
        busy      <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= vec_addr;
        mem_wdata <= vec_lanes[0];
      end else if (sc_gnt) begin
        state     <= IDLE;
        busy      <= 1'b0;
        mem_we    <= 1'b1;
        mem_addr  <= sc_addr;
        mem_wdata <= sc_data;
      end else if (step) begin
        mem_we    <= 1'b1;
        mem_addr  <= nxt_addr;
        mem_wdata <= nxt_data;
      end else begin
        // Address and data hold their last value while the port is idle.
        state     <= IDLE;
        busy      <= 1'b0;
        mem_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_store_arbiter.sv
// Self-checking bench for mem_store_arbiter with a write scoreboard.
// Latency: expectations are queued at each grant and matched against the write port.
// Backpressure: every wait on a grant is bounded by a cycle budget.
module tb_mem_store_arbiter;
  import mem_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               sc_req;
  logic [ADDR_W-1:0]  sc_addr;
  logic [DATA_W-1:0]  sc_data;
  logic               vec_req;
  logic [ADDR_W-1:0]  vec_addr;
  lane_vec_t          vec_data;
  logic               sc_gnt;
  logic               vec_gnt;
  logic               stall;
  logic               busy;
  logic               vec_done;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              done;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  int  w;
  int  busy_cnt;

  mem_store_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .sc_req    (sc_req),
    .sc_addr   (sc_addr),
    .sc_data   (sc_data),
    .vec_req   (vec_req),
    .vec_addr  (vec_addr),
    .vec_data  (vec_data),
    .sc_gnt    (sc_gnt),
    .vec_gnt   (vec_gnt),
    .stall     (stall),
    .busy      (busy),
    .vec_done  (vec_done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] seed);
    vec_addr = base;
    for (int i = 0; i < LANES; i++) vec_data[i] = seed + DATA_W'(i);
  endtask

  task automatic push_vec(input logic [ADDR_W-1:0] base, input lane_vec_t lanes);
    for (int i = 0; i < LANES; i++)
      exp_q.push_back({base + ADDR_W'(i), lanes[i], (i == LANES - 1)});
  endtask

  // Wait (bounded) for a grant; the bench states which side should win and
  // queues the writes that side must produce.
  task automatic wait_gnt(input bit want_vec, input int budget, output int waited);
    waited = 0;
    @(negedge clk);
    while (!(sc_gnt || vec_gnt) && waited < budget) begin
      chk_eq("stall_while_waiting", 32'(stall), 32'd1);
      waited++;
      @(negedge clk);
    end
    if (!(sc_gnt || vec_gnt)) begin
      chk_eq("gnt_timeout", {30'b0, sc_gnt, vec_gnt}, want_vec ? 32'd1 : 32'd2);
    end else begin
      chk_eq("gnt_side", {30'b0, sc_gnt, vec_gnt}, want_vec ? 32'd1 : 32'd2);
      if (want_vec) push_vec(vec_addr, vec_data);
      else exp_q.push_back({sc_addr, sc_data, 1'b0});
    end
  endtask

  // Write-port monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk_eq("spurious_write", 32'(mem_we), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("wr_addr", 32'(mem_addr), 32'(mon_e.a));
          chk_eq("wr_data", 32'(mem_wdata), 32'(mon_e.d));
          chk_eq("wr_done", 32'(vec_done), 32'(mon_e.done));
        end
      end else begin
        chk_eq("done_without_write", 32'(vec_done), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requests asserted: no grants, port quiet.
    rst     = 1'b0;
    sc_req  = 1'b1;
    vec_req = 1'b1;
    sc_addr = 16'h1234;
    sc_data = 16'h5678;
    set_vec(16'h0A00, 16'hAA00);
    repeat (2) begin
      tick;
      @(negedge clk);
      chk_eq("rst_sc_gnt",   32'(sc_gnt),   32'd0);
      chk_eq("rst_vec_gnt",  32'(vec_gnt),  32'd0);
      chk_eq("rst_mem_we",   32'(mem_we),   32'd0);
      chk_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk_eq("rst_busy",     32'(busy),     32'd0);
      chk_eq("rst_vec_done", 32'(vec_done), 32'd0);
    end
    tick;
    rst     = 1'b1;
    sc_req  = 1'b0;
    vec_req = 1'b0;
    mon_en  = 1'b1;

    // Scalar only.
    sc_addr = 16'h0040;
    sc_data = 16'hBEEF;
    sc_req  = 1'b1;
    wait_gnt(1'b0, 4, w);
    chk_eq("sc_gnt_immediate", 32'(w), 32'd0);
    tick;
    sc_req = 1'b0;
    @(negedge clk);
    chk_eq("sc_write_next", 32'(mem_we), 32'd1);
    tick;
    @(negedge clk);
    chk_eq("sc_we_drops", 32'(mem_we), 32'd0);

    // Vector only; inputs are scribbled after the grant.
    tick;
    set_vec(16'h0100, 16'h1000);
    vec_req = 1'b1;
    wait_gnt(1'b1, 4, w);
    tick;
    vec_req = 1'b0;
    vec_data = '1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk_eq("busy_cycles", 32'(busy_cnt), 32'd16);

    // Contention from idle, prio 0: scalar first, vector right after.
    tick;
    sc_addr = 16'h0050;
    sc_data = 16'hA5A5;
    set_vec(16'h0400, 16'h2000);
    sc_req  = 1'b1;
    vec_req = 1'b1;
    wait_gnt(1'b0, 4, w);
    tick;
    sc_req = 1'b0;
    wait_gnt(1'b1, 2, w);
    chk_eq("vec_after_sc_wait", 32'(w), 32'd0);
    tick;
    vec_req = 1'b0;
    repeat (18) tick;

    // Contention again: vector now wins, scalar waits for the last lane.
    sc_addr = 16'h0060;
    sc_data = 16'h5A5A;
    set_vec(16'h0500, 16'h3000);
    sc_req  = 1'b1;
    vec_req = 1'b1;
    wait_gnt(1'b1, 4, w);
    tick;
    vec_req = 1'b0;
    wait_gnt(1'b0, 20, w);
    chk_eq("sc_wait_behind_burst", 32'(w), 32'd15);
    tick;
    sc_req = 1'b0;
    repeat (3) tick;

    // Scalar arriving at lane 3 stalls until the lane-15 cycle.
    set_vec(16'h0200, 16'h4000);
    vec_req = 1'b1;
    wait_gnt(1'b1, 4, w);
    tick;
    vec_req = 1'b0;
    repeat (3) tick;
    sc_addr = 16'h0070;
    sc_data = 16'hC0DE;
    sc_req  = 1'b1;
    wait_gnt(1'b0, 20, w);
    chk_eq("sc_stall_from_lane3", 32'(w), 32'd12);
    tick;
    sc_req = 1'b0;
    repeat (3) tick;

    // Back-to-back vector bursts with no bubble.
    set_vec(16'h0600, 16'h5000);
    vec_req = 1'b1;
    wait_gnt(1'b1, 4, w);
    tick;
    vec_req = 1'b0;
    tick;
    set_vec(16'h0700, 16'h6000);
    vec_req = 1'b1;
    wait_gnt(1'b1, 20, w);
    chk_eq("b2b_grant_at_last", 32'(w), 32'd14);
    tick;
    vec_req  = 1'b0;
    vec_data = '0;
    @(negedge clk);
    chk_eq("b2b_no_bubble_we",   32'(mem_we),   32'd1);
    chk_eq("b2b_no_bubble_addr", 32'(mem_addr), 32'h0700);
    chk_eq("b2b_busy",           32'(busy),     32'd1);
    repeat (18) tick;

    // Address wrap at the top of memory.
    set_vec(16'hFFFE, 16'h7000);
    vec_req = 1'b1;
    wait_gnt(1'b1, 4, w);
    tick;
    vec_req = 1'b0;
    repeat (18) tick;

    // Reset during lane 7: burst aborts after lane 6.
    set_vec(16'h0300, 16'h8000);
    vec_req = 1'b1;
    wait_gnt(1'b1, 4, w);
    tick;
    vec_req = 1'b0;
    repeat (6) tick;
    rst = 1'b0;
    tick;
    @(negedge clk);
    chk_eq("abort_mem_we",    32'(mem_we),   32'd0);
    chk_eq("abort_busy",      32'(busy),     32'd0);
    chk_eq("abort_vec_done",  32'(vec_done), 32'd0);
    chk_eq("abort_remaining", 32'(exp_q.size()), 32'd9);
    exp_q.delete();
    tick;
    rst = 1'b1;

    // Priority is back to scalar-first after reset.
    sc_addr = 16'h0080;
    sc_data = 16'h1111;
    set_vec(16'h0900, 16'h9000);
    sc_req  = 1'b1;
    vec_req = 1'b1;
    wait_gnt(1'b0, 4, w);
    chk_eq("post_rst_idle_gnt", 32'(w), 32'd0);
    tick;
    sc_req = 1'b0;
    wait_gnt(1'b1, 2, w);
    tick;
    vec_req = 1'b0;
    repeat (20) tick;

    chk_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
